fetch_controller: RTL

Sequences the instruction-fetch stage of the MIPS pipeline: owns the program counter, arbitrates the single instruction-memory port between the program loader and the fetch path, and implements run / single-step / halt execution modes for the debug unit. Sits between the hazard unit, branch/jump resolution logic and the instruction memory. Produces the fetch address and the IF/ID latch-enable.

---
 rtl/fetch_controller_if.sv | 43 ++++
 rtl/fetch_controller.sv | 86 ++++++++
 2 files changed

// File: rtl/fetch_controller_if.sv
// Bus bundle between the fetch controller and its surroundings: loader, debug
// mode controls, hazard/redirect inputs, instruction-memory port and IF/ID outputs.
interface fetch_controller_if #(
    parameter int B = 32
);
    logic         load_we;
    logic [B-1:0] load_addr;
    logic [31:0]  load_data;
    logic         load_done;
    logic         run_mode;
    logic         step_req;
    logic         stall;
    logic         branch_taken;
    logic [B-1:0] branch_target;
    logic         jump_taken;
    logic [B-1:0] jump_target;
    logic [31:0]  instruction;
    logic [B-1:0] mem_addr;
    logic         mem_we;
    logic [31:0]  mem_wdata;
    logic [B-1:0] pc;
    logic [B-1:0] pc_plus4;
    logic         fetch_valid;
    logic         halted;
    logic [1:0]   state;
    logic [31:0]  instr_count;

    modport slave (
        input  load_we, load_addr, load_data, load_done, run_mode, step_req,
               stall, branch_taken, branch_target, jump_taken, jump_target,
               instruction,
        output mem_addr, mem_we, mem_wdata, pc, pc_plus4, fetch_valid, halted,
               state, instr_count
    );

    modport master (
        output load_we, load_addr, load_data, load_done, run_mode, step_req,
               stall, branch_taken, branch_target, jump_taken, jump_target,
               instruction,
        input  mem_addr, mem_we, mem_wdata, pc, pc_plus4, fetch_valid, halted,
               state, instr_count
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, shares the instruction-memory port
// with the program loader, and implements run / single-step / halt modes.
module fetch_controller #(
    parameter int          B         = 32,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               reset,
    fetch_controller_if.slave  bus
);
    localparam logic [1:0] S_LOAD = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STEP = 2'b10;
    localparam logic [1:0] S_HALT = 2'b11;

    logic [1:0]   state_q, state_d;
    logic [B-1:0] pc_q, pc_d;
    logic [31:0]  count_q, count_d;

    logic         in_load, in_halt;
    logic         fetch_en, redirect, halt_hit, fetch_valid;
    logic [B-1:0] target_raw, target;

    assign in_load = (state_q == S_LOAD);
    assign in_halt = (state_q == S_HALT);

    assign fetch_en = (state_q == S_RUN) | ((state_q == S_STEP) & bus.step_req);

    // Jump beats branch; targets are forced word-aligned.
    assign redirect   = bus.jump_taken | bus.branch_taken;
    assign target_raw = bus.jump_taken ? bus.jump_target : bus.branch_target;
    assign target     = {target_raw[B-1:2], 2'b00};

    // A redirect squashes whatever word is currently on the memory bus.
    assign halt_hit    = fetch_en & ~bus.stall & ~redirect & (bus.instruction == HALT_WORD);
    assign fetch_valid = fetch_en & ~bus.stall & ~redirect & ~halt_hit;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;

        case (state_q)
            S_LOAD: if (bus.load_done) state_d = bus.run_mode ? S_RUN : S_STEP;
            S_RUN: begin
                if (halt_hit)           state_d = S_HALT;
                else if (!bus.run_mode) state_d = S_STEP;
            end
            S_STEP: begin
                if (halt_hit)          state_d = S_HALT;
                else if (bus.run_mode) state_d = S_RUN;
            end
            default: state_d = state_q;
        endcase

        // Redirect overrides a stall; a halt word leaves the PC pointing at it.
        if (!in_load && !in_halt) begin
            if (redirect)         pc_d = target;
            else if (fetch_valid) pc_d = pc_q + B'(4);
        end

        if (fetch_valid) count_d = count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_LOAD;
            pc_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    assign bus.mem_addr    = in_load ? bus.load_addr : pc_q;
    assign bus.mem_wdata   = in_load ? bus.load_data : 32'd0;
    assign bus.mem_we      = in_load & bus.load_we;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_q + B'(4);
    assign bus.fetch_valid = fetch_valid;
    assign bus.halted      = in_halt;
    assign bus.state       = state_q;
    assign bus.instr_count = count_q;
endmodule
